golden_nonce_collector: RTL
===========================

GOLDEN_NONCE_COLLECTOR -- requirements
Module: golden_nonce_collector

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: global clock; all state changes on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: global reset, asynchronous, active-low.
REQ-003 SHALL have port `start`, input, 1 bit: single-cycle pulse; arms a new job.
REQ-004 SHALL have port `stop`, input, 1 bit: level; aborts the job.
REQ-005 SHALL have port `result`, input, 1 bit: sticky compare result from the comparator; 1 = hash below target.
REQ-006 SHALL have port `heavy_hash_din`, input, 256 bits: assembled hash from the comparator.
REQ-007 SHALL have port `nonce_din`, input, 32 bits: nonce word from the nonce FIFO.
REQ-008 SHALL have port `nonce_din_we`, input, 1 bit: `nonce_din` valid this cycle; marks one completed compare.
REQ-009 SHALL have port `dout`, output, 32 bits: host result word.
REQ-010 SHALL have port `dout_valid`, output, 1 bit: `dout` valid.
REQ-011 SHALL have port `dout_ready`, input, 1 bit: host accepts `dout`.
REQ-012 SHALL have port `found`, output, 1 bit: golden nonce captured for this job; drives miner stop.
REQ-013 SHALL have port `nonce_count`, output, 32 bits: compares completed since the last `start`.

Function
REQ-014 SHALL implement states IDLE, ARMED, SEND, DONE.
REQ-015 SHALL move from IDLE to ARMED on `start`; all other inputs SHALL be ignored in IDLE.
REQ-016 SHALL, in ARMED on `nonce_din_we`=1, increment `nonce_count`, saturating at 0xFFFFFFFF with no wrap.
REQ-017 SHALL, in ARMED on `nonce_din_we`=1 with `result`=1, register `nonce_din` and `heavy_hash_din`, set `found`, and go to SEND in the same cycle.
REQ-018 SHALL ignore `result` when `nonce_din_we`=0.
REQ-019 SHALL drive `dout_valid` high in every cycle spent in SEND; first `dout_valid` SHALL appear the cycle after the capture edge (latency 1).
REQ-020 SHALL send word order: word 0 = nonce; words 1..8 = hash[255:224], hash[223:192], ... down to hash[31:0].
REQ-021 SHALL hold `dout` and `dout_valid` stable until `dout_ready`=1; the word index SHALL advance only on `dout_valid` && `dout_ready`.
REQ-022 SHALL go to DONE after the last word is accepted; `dout_valid` SHALL be 0 in DONE.
REQ-023 SHALL keep counting `nonce_din_we` in SEND and DONE (saturating) but SHALL NOT capture again, even with `result`=1.
REQ-024 SHALL hold `found`=1 in SEND and DONE, and 0 in IDLE and ARMED.
REQ-025 SHALL, on `start` in any state, clear `found`, `nonce_count` and the word index and enter ARMED; a transfer in progress SHALL be abandoned and `dout_valid` SHALL be 0 from the next cycle.
REQ-026 SHALL, on `stop` in any state, enter IDLE with the same clearing as REQ-025; `stop` SHALL win over `start` when both are 1 in the same cycle.
REQ-027 SHALL give `start` and `stop` priority over `nonce_din_we` in the same cycle; that nonce SHALL be neither counted nor captured.

Reset
REQ-028 SHALL, while `rst`=0, immediately force state IDLE, `dout`=0, `dout_valid`=0, `found`=0, `nonce_count`=0, word index 0, and nonce/hash capture registers 0.
REQ-029 SHALL, when reset is asserted mid-SEND, drop `dout_valid` asynchronously and discard the captured nonce and hash.
REQ-030 SHALL treat reset deassertion as synchronous to `clk`; the first state change SHALL be no earlier than the first rising edge after `rst` goes high.

Configuration
REQ-031 SHALL, when macro GOLDEN_HASH_EN is defined, capture the hash and send 9 words (nonce followed by 8 hash words).
REQ-032 SHALL, when GOLDEN_HASH_EN is not defined, omit the 256-bit capture register, leave `heavy_hash_din` unused, send only word 0 (nonce), and go from SEND to DONE after that single accepted word.

Verification
REQ-033 Bench SHALL cover: start; 5 nonce_din_we with result=0 -> nonce_count=5, found=0, dout_valid never 1.
REQ-034 Bench SHALL cover: start; nonce_din=0x1234ABCD with result=1, hash=0x0123...CDEF pattern, dout_ready=1 -> found=1 next cycle; dout sequence 0x1234ABCD then 8 hash words MSW first (only 0x1234ABCD when GOLDEN_HASH_EN is not defined); then DONE.
REQ-035 Bench SHALL cover: capture with dout_ready toggling 1-0-0-1 -> each word held while ready=0; no word skipped or duplicated.
REQ-036 Bench SHALL cover: capture, then start during word 3 -> dout_valid=0 next cycle, found=0, nonce_count=0, state ARMED.
REQ-037 Bench SHALL cover: start and stop both 1 with nonce_din_we=1, result=1 -> IDLE, found=0, count unchanged at 0.
REQ-038 Bench SHALL cover: rst=0 asserted mid-SEND between clock edges -> dout_valid and found 0 before the next edge; after release, IDLE.

Source files
------------

// File: rtl/golden_nonce_collector.sv
// ---------------------------------------------------------------------------
// golden_nonce_collector
//
// Watches the comparator/nonce-FIFO stream for the first nonce whose hash
// falls below target. It captures that nonce and, optionally, its 256-bit
// hash. The captured data is then streamed to the host as 32-bit words over
// a valid/ready handshake.
//
// Configuration macro: GOLDEN_HASH_EN
//   defined   : the hash is captured, and 9 words are sent
//               (nonce, then hash[255:224] down to hash[31:0]).
//   undefined : only the nonce is sent, and heavy_hash_din is unused.
//
// Ports
//   clk            in   clock, all state changes on its rising edge
//   rst            in   asynchronous active-low reset
//   start          in   single-cycle pulse, arms a new job
//   stop           in   level, aborts the job (wins over start)
//   result         in   comparator verdict, 1 = hash below target
//   heavy_hash_din in   256-bit assembled hash
//   nonce_din      in   nonce word from the nonce FIFO
//   nonce_din_we   in   nonce_din valid, one completed compare
//   dout           out  host result word
//   dout_valid     out  dout valid
//   dout_ready     in   host accepts dout
//   found          out  golden nonce captured for this job
//   nonce_count    out  compares completed since the last start (saturating)
// ---------------------------------------------------------------------------
module golden_nonce_collector (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         result,
  input  logic [255:0] heavy_hash_din,
  input  logic [31:0]  nonce_din,
  input  logic         nonce_din_we,
  output logic [31:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         found,
  output logic [31:0]  nonce_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef GOLDEN_HASH_EN
  localparam logic [3:0] LAST_WORD = 4'd8;
`else
  localparam logic [3:0] LAST_WORD = 4'd0;
`endif

  state_t       state_r, state_nx_s;
  logic [3:0]   word_idx_r, word_idx_nx_s;
  logic [31:0]  count_r, count_nx_s;
  logic [31:0]  nonce_r, nonce_nx_s;
  logic [31:0]  dout_r, dout_nx_s;
  logic         dout_valid_r;
  logic         found_r;
  logic         count_en_s;

`ifdef GOLDEN_HASH_EN
  logic [255:0] hash_r, hash_nx_s;

  // Selects hash word 1..8, most significant word first; index 0 is the nonce.
  function automatic logic [31:0] hash_word(input logic [255:0] h, input logic [3:0] idx);
    case (idx)
      4'd1:    hash_word = h[255:224];
      4'd2:    hash_word = h[223:192];
      4'd3:    hash_word = h[191:160];
      4'd4:    hash_word = h[159:128];
      4'd5:    hash_word = h[127:96];
      4'd6:    hash_word = h[95:64];
      4'd7:    hash_word = h[63:32];
      4'd8:    hash_word = h[31:0];
      default: hash_word = 32'd0;
    endcase
  endfunction
`else
  // The hash is not captured in this build. Reduce it so the port is still consumed.
  logic unused_hash_s;
  assign unused_hash_s = ^heavy_hash_din;
`endif

  // Next-state, counter, capture and word-index logic.
  always_comb begin
    state_nx_s    = state_r;
    word_idx_nx_s = word_idx_r;
    count_nx_s    = count_r;
    nonce_nx_s    = nonce_r;
`ifdef GOLDEN_HASH_EN
    hash_nx_s     = hash_r;
`endif
    // Completed compares count in every state except IDLE.
    count_en_s    = nonce_din_we && (state_r != IDLE);

    if (stop) begin
      // stop wins over start, and both override any nonce this cycle.
      state_nx_s    = IDLE;
      word_idx_nx_s = 4'd0;
      count_nx_s    = 32'd0;
    end else if (start) begin
      state_nx_s    = ARMED;
      word_idx_nx_s = 4'd0;
      count_nx_s    = 32'd0;
    end else begin
      if (count_en_s && (count_r != 32'hFFFF_FFFF)) begin
        count_nx_s = count_r + 32'd1;
      end else begin
        count_nx_s = count_r;
      end

      case (state_r)
        IDLE: begin
          state_nx_s = IDLE;
        end
        ARMED: begin
          if (nonce_din_we && result) begin
            state_nx_s    = SEND;
            word_idx_nx_s = 4'd0;
            nonce_nx_s    = nonce_din;
`ifdef GOLDEN_HASH_EN
            hash_nx_s     = heavy_hash_din;
`endif
          end else begin
            state_nx_s = ARMED;
          end
        end
        SEND: begin
          if (dout_valid_r && dout_ready) begin
            if (word_idx_r == LAST_WORD) begin
              state_nx_s    = DONE;
              word_idx_nx_s = 4'd0;
            end else begin
              word_idx_nx_s = word_idx_r + 4'd1;
            end
          end else begin
            word_idx_nx_s = word_idx_r;
          end
        end
        DONE: begin
          state_nx_s = DONE;
        end
        default: begin
          state_nx_s    = IDLE;
          word_idx_nx_s = 4'd0;
        end
      endcase
    end
  end

  // Output word for the next cycle. It is built from next-cycle values so that
  // dout is registered and valid one cycle after the capture edge.
  always_comb begin
    dout_nx_s = 32'd0;
    if (state_nx_s == SEND) begin
      if (word_idx_nx_s == 4'd0) begin
        dout_nx_s = nonce_nx_s;
      end else begin
`ifdef GOLDEN_HASH_EN
        dout_nx_s = hash_word(hash_nx_s, word_idx_nx_s);
`else
        dout_nx_s = nonce_nx_s;
`endif
      end
    end else begin
      dout_nx_s = 32'd0;
    end
  end

  // State and registered outputs. Reset clears everything, including captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      word_idx_r   <= 4'd0;
      count_r      <= 32'd0;
      nonce_r      <= 32'd0;
      dout_r       <= 32'd0;
      dout_valid_r <= 1'b0;
      found_r      <= 1'b0;
`ifdef GOLDEN_HASH_EN
      hash_r       <= 256'd0;
`endif
    end else begin
      state_r      <= state_nx_s;
      word_idx_r   <= word_idx_nx_s;
      count_r      <= count_nx_s;
      nonce_r      <= nonce_nx_s;
      dout_r       <= dout_nx_s;
      dout_valid_r <= (state_nx_s == SEND);
      found_r      <= (state_nx_s == SEND) || (state_nx_s == DONE);
`ifdef GOLDEN_HASH_EN
      hash_r       <= hash_nx_s;
`endif
    end
  end

  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign found       = found_r;
  assign nonce_count = count_r;

endmodule
